// File: rtl/stage_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : stage_pipeline
// Description : DEPTH-stage valid/ready elastic data pipeline, WIDTH bits
//               wide. Stalled stages hold and bubbles collapse forward.
//               Provides flush, per-stage occupancy and occupancy count.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module stage_pipeline #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DEPTH-1:0]           occ_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int C_CNT_W = $clog2(DEPTH + 1);

  // Reject degenerate configurations at elaboration time.
  generate
    if (WIDTH < 1) begin : g_width_check
      $error("stage_pipeline: WIDTH must be >= 1");
    end
    if (DEPTH < 1) begin : g_depth_check
      $error("stage_pipeline: DEPTH must be >= 1");
    end
  endgenerate

  logic [DEPTH-1:0]   r_valid;
  logic [WIDTH-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0]   w_adv;
  logic [DEPTH-1:0]   w_load;
  logic               w_ready;
  logic [C_CNT_W-1:0] w_count;

  // Advance terms. The recursive form adv[k] = v[k] & (~v[k+1] | adv[k+1])
  // unrolls to "stage k is valid and either the output is being taken or
  // some later stage is empty", which is expressed here without a chain.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_adv
      if (k == DEPTH - 1) begin : g_last
        assign w_adv[k] = r_valid[k] & ready_i;
      end else begin : g_inner
        assign w_adv[k] = r_valid[k] & (ready_i | ~(&r_valid[DEPTH-1:k+1]));
      end
    end
  endgenerate

  // Input side may accept when stage 0 is empty or draining this cycle.
  assign w_ready = ~r_valid[0] | w_adv[0];

  // Load strobes; flush suppresses every load so data is left untouched.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_load
      if (k == 0) begin : g_first
        assign w_load[k] = valid_i & w_ready & ~flush_i;
      end else begin : g_next
        assign w_load[k] = w_adv[k-1] & ~flush_i;
      end
    end
  endgenerate

  // Valid bits: set on load, cleared when the stage moves on, cleared by flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_load | (r_valid & ~w_adv);
    end
  end

  // Data registers change only on a load; stalled or emptied stages hold.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_first
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            r_data[k] <= RESET_VALUE;
          end else if (w_load[k]) begin
            r_data[k] <= data_i;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            r_data[k] <= RESET_VALUE;
          end else if (w_load[k]) begin
            r_data[k] <= r_data[k-1];
          end
        end
      end
    end
  endgenerate

  // Population count of the valid vector.
  always_comb begin
    w_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + C_CNT_W'(r_valid[k]);
    end
  end

  assign ready_o = w_ready;
  assign data_o  = r_data[DEPTH-1];
  assign valid_o = r_valid[DEPTH-1];
  assign occ_o   = r_valid;
  assign count_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_stage_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_pipeline
// Description : Self-checking bench for stage_pipeline (DEPTH=4 and DEPTH=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_pipeline;

  localparam int         W  = 8;
  localparam int         D  = 4;
  localparam logic [7:0] RV = 8'h3C;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_in = 1'b0;
  logic [W-1:0] data_in = '0;

  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic [D-1:0] occ;
  logic [2:0]   count;

  logic         valid2 = 1'b0;
  logic         ready2 = 1'b0;
  logic [15:0]  data2 = '0;
  logic         ready_o2;
  logic         valid_o2;
  logic [15:0]  data_o2;
  logic         occ2;
  logic         count2;

  stage_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .data_i  (data_in),
    .valid_i (valid_in),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_in),
    .occ_o   (occ),
    .count_o (count)
  );

  stage_pipeline #(.WIDTH(16), .DEPTH(1)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (1'b0),
    .data_i  (data2),
    .valid_i (valid2),
    .ready_o (ready_o2),
    .data_o  (data_o2),
    .valid_o (valid_o2),
    .ready_i (ready2),
    .occ_o   (occ2),
    .count_o (count2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- Reference model for the DEPTH=4 instance ----------------
  // Slot array: each cycle the output word leaves if taken, then every word
  // slides one slot forward into an empty slot ahead of it (top-down pass).
  logic [D-1:0] mv, pv;
  logic [W-1:0] md [D];
  logic [W-1:0] pd [D];
  logic         p_ready;

  task automatic predict();
    pv = mv;
    for (int k = 0; k < D; k++) pd[k] = md[k];
    if (ready_in && pv[D-1]) pv[D-1] = 1'b0;
    for (int k = D - 2; k >= 0; k--) begin
      if (pv[k] && !pv[k+1]) begin
        pv[k+1] = 1'b1;
        pv[k]   = 1'b0;
        pd[k+1] = pd[k];
      end
    end
    p_ready = !pv[0];
    if (flush) begin
      pv = '0;
      for (int k = 0; k < D; k++) pd[k] = md[k];
    end else if (valid_in && p_ready) begin
      pv[0] = 1'b1;
      pd[0] = data_in;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv = '0;
      for (int k = 0; k < D; k++) md[k] = RV;
    end else begin
      predict();
      mv = pv;
      for (int k = 0; k < D; k++) md[k] = pd[k];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      predict();
      chk("ready_o", ready_o, p_ready);
      chk("valid_o", valid_o, mv[D-1]);
      chk("data_o", data_o, md[D-1]);
      chk("occ_o", occ, mv);
      chk("count_o", count, $countones(mv));
    end
  end

  // ---------------- Scoreboard for the DEPTH=1 instance ----------------
  logic [15:0] sb_q[$];
  logic        r2;
  logic        f_out2 = 1'b0;
  int          sent2 = 0;
  int          dut_out2 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("d1_ready_o", ready_o2, (sb_q.size() == 0) || ready2);
      chk("d1_valid_o", valid_o2, sb_q.size() != 0);
      chk("d1_occ_o", occ2, sb_q.size() != 0);
      chk("d1_count_o", count2, sb_q.size());
      if (sb_q.size() != 0) chk("d1_data_o", data_o2, sb_q[0]);
      f_out2 = valid_o2 & ready2;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
      f_out2 = 1'b0;
    end else begin
      r2 = (sb_q.size() == 0) || ready2;
      if (sb_q.size() != 0 && ready2) void'(sb_q.pop_front());
      if (valid2 && r2) begin
        sb_q.push_back(data2);
        sent2++;
      end
      if (f_out2) dut_out2++;
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- Directed and random stimulus ----------------
  initial begin
    int acc;
    logic seen55;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_data_o", data_o, 8'h3C);
    chk("rst_occ_o", occ, 4'b0000);
    chk("rst_count_o", count, 3'd0);
    rst = 1'b0;

    // Stream 0x01..0x08 with ready held high.
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(i + 1);
      cyc();
      if (i == 3) begin
        chk("stream_first_valid", valid_o, 1'b1);
        chk("stream_first_data", data_o, 8'h01);
        chk("stream_count_4", count, 3'd4);
      end
      if (i == 7) begin
        chk("stream_steady_data", data_o, 8'h05);
        chk("stream_steady_count", count, 3'd4);
      end
    end
    valid_in = 1'b0;
    repeat (6) cyc();
    chk("stream_drained", occ, 4'b0000);

    // Fill and stall.
    ready_in = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1;
      data_in  = 8'hA0 + 8'(i);
      #1;
      if (ready_o) acc++;
      cyc();
    end
    valid_in = 1'b0;
    chk("fill_accepted", acc, 4);
    chk("fill_ready_o", ready_o, 1'b0);
    chk("fill_occ_o", occ, 4'b1111);
    chk("fill_count_o", count, 3'd4);
    chk("fill_data_o", data_o, 8'hA0);
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", valid_o, 1'b1);
      chk("drain_data", data_o, 8'hA0 + 8'(i));
      cyc();
    end
    chk("drain_empty", occ, 4'b0000);

    // Bubble collapse under output stall.
    ready_in = 1'b0;
    valid_in = 1'b1; data_in = 8'h11; cyc();
    valid_in = 1'b0; cyc(); cyc();
    valid_in = 1'b1; data_in = 8'h22; cyc();
    valid_in = 1'b0; cyc(); cyc();
    chk("bubble_occ_o", occ, 4'b1100);
    chk("bubble_count_o", count, 3'd2);
    chk("bubble_data_o", data_o, 8'h11);
    ready_in = 1'b1;
    #1;
    chk("bubble_out1", data_o, 8'h11);
    cyc();
    chk("bubble_out2_valid", valid_o, 1'b1);
    chk("bubble_out2", data_o, 8'h22);
    cyc();
    chk("bubble_empty", occ, 4'b0000);

    // Flush with simultaneous input.
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = 8'h31 + 8'(i);
      cyc();
    end
    chk("flush_pre_count", count, 3'd3);
    valid_in = 1'b1; data_in = 8'h55; flush = 1'b1;
    cyc();
    flush = 1'b0; valid_in = 1'b0;
    chk("flush_occ_o", occ, 4'b0000);
    chk("flush_valid_o", valid_o, 1'b0);
    chk("flush_count_o", count, 3'd0);
    ready_in = 1'b1;
    seen55 = 1'b0;
    repeat (6) begin
      #1;
      if (valid_o && data_o == 8'h55) seen55 = 1'b1;
      cyc();
    end
    chk("flush_no_55", seen55, 1'b0);

    // Asynchronous reset with three words in flight.
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = 8'h61 + 8'(i);
      cyc();
    end
    valid_in = 1'b0;
    chk("arst_pre_occ", occ, 4'b0111);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid_o", valid_o, 1'b0);
    chk("arst_occ_o", occ, 4'b0000);
    chk("arst_count_o", count, 3'd0);
    chk("arst_data_o", data_o, 8'h3C);
    #1 rst = 1'b0;
    cyc();
    chk("arst_post_occ", occ, 4'b0000);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      data_in  = 8'($urandom);
      ready_in = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      cyc();
    end
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    repeat (6) cyc();
    chk("random_drained", occ, 4'b0000);

    // DEPTH=1: continuous valid, ready toggling every cycle.
    for (int i = 0; i < 60; i++) begin
      valid2 = 1'b1;
      data2  = 16'h1000 + 16'(i);
      ready2 = (i % 2 == 0);
      cyc();
    end
    valid2 = 1'b0; ready2 = 1'b1;
    repeat (4) cyc();
    chk("d1_out_count", dut_out2, sent2);
    chk("d1_final_valid", valid_o2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_pipeline.md
Name: stage_pipeline

Overview:
- Parametrised successor to the fixed 8-entry packed register block: a DEPTH-stage valid/ready data pipeline of WIDTH bits with per-stage occupancy tracking.
- Stalled stages hold, and bubbles collapse: a stage advances whenever the stage after it is empty or itself advancing.
- Sits between streaming producers and consumers as a retiming and elastic-buffering element.
- Adds flush, occupancy vector, occupancy count and a programmable reset data value.

Parameters:
- WIDTH, 8, data width in bits; must be >= 1, and WIDTH == 0 must fail elaboration.
- DEPTH, 4, number of pipeline stages; must be >= 1, and DEPTH == 0 must fail elaboration.
- RESET_VALUE, 0, WIDTH-bit value loaded into every data stage on reset.

Ports:
- clk_i  input  1  sole clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- flush_i  input  1  synchronous clear of all stage valid bits.
- data_i  input  WIDTH  input data.
- valid_i  input  1  input data valid.
- ready_o  output  1  pipeline can accept input this cycle.
- data_o  output  WIDTH  data of the last stage, DEPTH-1.
- valid_o  output  1  last stage holds valid data.
- ready_i  input  1  downstream accepts data_o this cycle.
- occ_o  output  DEPTH  per-stage valid bits; bit k = stage k.
- count_o  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (rst_i high, asynchronous):
  - all v[k] = 0; all d[k] = RESET_VALUE.
  - valid_o = 0, data_o = RESET_VALUE, occ_o = 0, count_o = 0.
  - Reset asserted mid-transfer discards all contents immediately; no partial state survives.
- State: v[k] (valid) and d[k] (data) for k = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives data_o/valid_o directly, with no output register beyond it.
- Advance terms, all combinational:
  - adv[DEPTH-1] = v[DEPTH-1] & ready_i.
  - adv[k] = v[k] & (~v[k+1] | adv[k+1]) for k < DEPTH-1.
- Input handshake:
  - ready_o = ~v[0] | adv[0]. ready_o is combinational from ready_i (this path is accepted).
  - Input transfer occurs when valid_i & ready_o.
  - Output transfer occurs when valid_o & ready_i.
- Per rising edge, when flush_i = 0:
  - stage 0 loads data_i and v[0] <= 1 on an input transfer; otherwise v[0] <= v[0] & ~adv[0].
  - stage k > 0 loads d[k-1] and v[k] <= 1 when adv[k-1]; otherwise v[k] <= v[k] & ~adv[k].
  - d[k] changes only on a load; stalled and emptied stages hold their last data.
- Latency and throughput:
  - With ready_i held high and an empty pipeline, a word accepted at edge n appears with valid_o = 1 after edge n+DEPTH-1, i.e. DEPTH edges from acceptance to being consumed at the output.
  - Sustained throughput is 1 word/cycle.
- Full: all v = 1 and ready_i = 0 gives ready_o = 0, and contents hold indefinitely.
  - Full with ready_i = 1 still accepts, since the whole chain advances.
- Bubble collapse: a valid stage moves forward into an empty successor even while the output is stalled.
- Flush (flush_i = 1 at an edge):
  - all v[k] <= 0.
  - Any simultaneous input is discarded; ready_o is not gated by flush_i.
  - An output transfer in the same cycle still counts as consumed downstream.
  - d[k] is untouched.
  - flush_i has priority over every load; reset has priority over flush_i.
- Observability outputs:
  - occ_o = v (combinational).
  - count_o = popcount(v) (combinational), range 0..DEPTH.
- DEPTH = 1: a single stage; ready_o = ~v[0] | ready_i.

Test Plan:
- Reset then stream: WIDTH=8, DEPTH=4, ready_i=1, valid_i=1 with data 0x01..0x08 on consecutive cycles -> data_o shows 0x01 on the 4th cycle after the first acceptance, then one word per cycle in order; count_o holds at 4 in steady state.
- Fill and stall: ready_i=0, push 0xA0..0xA5 -> exactly 4 accepted (0xA0..0xA3), ready_o=0 from then on, occ_o=4'b1111, count_o=4, data_o=0xA0 held; then raise ready_i -> 0xA0..0xA3 drain in order, 1 per cycle.
- Bubble collapse: with ready_i=0, push 0x11, idle 2 cycles, push 0x22 -> within 4 cycles occ_o=4'b1100 and count_o=2, with no gap stage between the two words.
- Flush: pipeline holding 3 words, assert flush_i for 1 cycle with valid_i=1 and data 0x55 -> next cycle occ_o=0, valid_o=0, count_o=0, and 0x55 never appears on data_o.
- Async reset mid-stream: assert rst_i between clock edges while 3 words are in flight -> valid_o, occ_o and count_o go to 0 and data_o goes to RESET_VALUE (test with 0x3C) immediately, without waiting for a clock edge.
- DEPTH=1, WIDTH=16: ready_i toggling 1/0 every cycle with continuous valid_i -> no word lost or duplicated; ready_o mirrors (~valid_o | ready_i).
